// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default sizing shared by the
// SPI FIFO master and its SCLK divider.
package spi_pkg;

   localparam int SPI_DATA_W = 32;
   localparam int SPI_DIV    = 4;
   localparam int SPI_CS_GAP = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period tick generator; ticks every DIV cycles
// while enabled and reloads whenever disabled.
module spi_sclk_div
   import spi_pkg::*;
#(
   parameter int DIV = SPI_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/spi_fifo_master.sv
// spi_fifo_master: pops TX FIFO words and sends them as SPI mode-0 frames.
// Define SPI_RX_EN to capture MISO and push received words to the RX FIFO.
module spi_fifo_master
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W,
   parameter int DIV    = SPI_DIV,
   parameter int CS_GAP = SPI_CS_GAP
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_empty_i,
   output logic              tx_pull_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_push_o,
   input  logic              rx_full_i,
   output logic              rx_ovf_o,
   output logic              busy_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic              cs_n_o
);

   localparam int BW = $clog2(DATA_W) + 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   spi_state_t        state;
   spi_state_t        state_nx;
   logic [DATA_W-1:0] tx_sh;
   logic [BW-1:0]     bit_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              div_en;
   logic              tick;
   logic              last_bit;
   logic              gap_done;
   logic              hold_done;

   assign div_en = (state == ST_SETUP) ||
                   (state == ST_SHIFT) ||
                   (state == ST_HOLD);

   spi_sclk_div #(
      .DIV (DIV)
   ) u_div (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (div_en),
      .tick  (tick)
   );

   // A tick while SCLK is high is a falling edge.
   assign last_bit  = tick && sclk_o &&
                      (bit_cnt == BW'(DATA_W - 1));
   assign gap_done  = (gap_cnt == GW'(CS_GAP - 1));
   assign hold_done = (state == ST_HOLD) && tick;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:
            if (enable_i && !tx_empty_i)
               state_nx = ST_LOAD;
         ST_LOAD:
            state_nx = ST_SETUP;
         ST_SETUP:
            if (tick)
               state_nx = ST_SHIFT;
         ST_SHIFT:
            if (last_bit)
               state_nx = ST_HOLD;
         ST_HOLD:
            if (tick)
               state_nx = ST_GAP;
         ST_GAP:
            if (gap_done)
               state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   // CS drops already in LOAD so the high time is GAP plus one IDLE cycle.
   assign tx_pull_o = (state == ST_LOAD);
   assign busy_o    = (state != ST_IDLE);
   assign cs_n_o    = !(div_en || (state == ST_LOAD));
   assign mosi_o    = div_en && tx_sh[DATA_W-1];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_sh   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         sclk_o  <= 1'b0;
      end else begin
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
         if (state == ST_LOAD) begin
            tx_sh   <= tx_data_i;
            bit_cnt <= '0;
         end
         if ((state == ST_SHIFT) && tick) begin
            sclk_o <= !sclk_o;
            if (sclk_o) begin
               tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

`ifdef SPI_RX_EN
   logic [DATA_W-1:0] rx_sh;
   logic              ovf;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rx_sh <= '0;
         ovf   <= 1'b0;
      end else begin
         if ((state == ST_SHIFT) && tick && !sclk_o)
            rx_sh <= {rx_sh[DATA_W-2:0], miso_i};
         if (hold_done && rx_full_i)
            ovf <= 1'b1;
      end
   end

   assign rx_data_o = rx_sh;
   assign rx_push_o = hold_done && !rx_full_i;
   assign rx_ovf_o  = ovf;
`else
   logic rx_unused;

   assign rx_unused = miso_i ^ rx_full_i ^ hold_done;
   assign rx_data_o = '0;
   assign rx_push_o = 1'b0;
   assign rx_ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo_master.sv
// tb_spi_fifo_master: table-driven frames with MOSI looped to MISO,
// plus back-to-back, idle, reset-abort and enable-drop sequences.
`timescale 1ns/1ps
module tb_spi_fifo_master;
   import spi_pkg::*;

   localparam int W = SPI_DATA_W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         rx_full = 1'b0;
   logic         tx_empty, tx_pull, rx_push, rx_ovf;
   logic         busy, sclk, mosi, cs_n;
   logic [W-1:0] tx_data, rx_data;

   always #5 clk = ~clk;

   spi_fifo_master dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .enable_i   (enable),
      .tx_data_i  (tx_data),
      .tx_empty_i (tx_empty),
      .tx_pull_o  (tx_pull),
      .rx_data_o  (rx_data),
      .rx_push_o  (rx_push),
      .rx_full_i  (rx_full),
      .rx_ovf_o   (rx_ovf),
      .busy_o     (busy),
      .sclk_o     (sclk),
      .mosi_o     (mosi),
      .miso_i     (mosi),
      .cs_n_o     (cs_n)
   );

   // TX FIFO model: head advances on the edge that ends the pull cycle
   logic [W-1:0] tx_mem [0:63];
   int           wr = 0;
   int           rd = 0;
   logic         pull_seen = 1'b0;

   assign tx_empty = (rd == wr);
   assign tx_data  = tx_mem[rd[5:0]];

   always @(negedge clk) pull_seen <= tx_pull;
   always @(posedge clk) if (pull_seen) rd <= rd + 1;

   // Bus monitor
   int           rises = 0, frames = 0, pulls = 0;
   int           pushes = 0, bad_pulls = 0, hi_run = 0;
   logic [W-1:0] acc = '0;
   logic         sclk_q = 1'b0, cs_q = 1'b1;
   logic [W-1:0] mosi_log [0:63];
   logic [W-1:0] rx_log [0:63];
   int           rise_log [0:63];
   int           gap_log [0:63];

   always @(negedge clk) begin
      if (!rst_n) begin
         rises  = 0;
         acc    = '0;
         sclk_q = 1'b0;
         cs_q   = 1'b1;
      end else begin
         if (sclk && !sclk_q) begin
            rises++;
            acc = {acc[W-2:0], mosi};
         end
         if (!cs_n && cs_q) begin
            gap_log[frames[5:0]] = hi_run;
            hi_run = 0;
         end
         if (cs_n) hi_run++;
         if (cs_n && !cs_q) begin
            mosi_log[frames[5:0]] = acc;
            rise_log[frames[5:0]] = rises;
            rises = 0;
            frames++;
         end
         if (tx_pull) pulls++;
         if (tx_pull && tx_empty) bad_pulls++;
         if (rx_push) begin
            rx_log[pushes[5:0]] = rx_data;
            pushes++;
         end
         sclk_q = sclk;
         cs_q   = cs_n;
      end
   end

   int           n_chk = 0;
   int           n_fail = 0;
   logic [W-1:0] sb [$];

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_frames(input int target, input string name);
      int t;
      t = 0;
      while (frames < target && t < 2000) begin
         cyc(1);
         t++;
      end
      check({name, " frame timeout"}, (frames >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_rises(input int n, input string name);
      int t;
      t = 0;
      while (rises < n && t < 2000) begin
         cyc(1);
         t++;
      end
      check({name, " rise timeout"}, (rises >= n) ? 1 : 0, 1);
   endtask

   task automatic put(input logic [W-1:0] w, input bit expect_out);
      tx_mem[wr[5:0]] = w;
      wr++;
      if (expect_out) sb.push_back(w);
   endtask

   task automatic check_frame(input int idx, input string name);
      logic [W-1:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      check({name, " mosi"}, mosi_log[idx], exp);
      check({name, " rises"}, rise_log[idx], W);
   endtask

   typedef struct {
      logic [W-1:0] word;
      logic         full;
      int           exp_push;
      logic         exp_ovf;
   } vec_t;

   localparam int NV = 7;
   vec_t tv [NV];

   int f0, p0, q0, bad;

   initial begin
`ifdef SPI_RX_EN
      tv[0] = '{32'hA5A55A5A, 1'b0, 1, 1'b0};
      tv[1] = '{32'h00000001, 1'b0, 1, 1'b0};
      tv[2] = '{32'hFFFFFFFF, 1'b0, 1, 1'b0};
      tv[3] = '{32'h12345678, 1'b0, 1, 1'b0};
      tv[4] = '{32'h80000000, 1'b0, 1, 1'b0};
      tv[5] = '{32'h7FFFFFFE, 1'b1, 0, 1'b1};
      tv[6] = '{32'hC3C3C3C3, 1'b0, 1, 1'b1};
`else
      tv[0] = '{32'hA5A55A5A, 1'b0, 0, 1'b0};
      tv[1] = '{32'h00000001, 1'b0, 0, 1'b0};
      tv[2] = '{32'hFFFFFFFF, 1'b0, 0, 1'b0};
      tv[3] = '{32'h12345678, 1'b0, 0, 1'b0};
      tv[4] = '{32'h80000000, 1'b0, 0, 1'b0};
      tv[5] = '{32'h7FFFFFFE, 1'b1, 0, 1'b0};
      tv[6] = '{32'hC3C3C3C3, 1'b0, 0, 1'b0};
`endif

      // Reset values
      cyc(3);
      check("rst cs_n", cs_n, 1);
      check("rst sclk", sclk, 0);
      check("rst mosi", mosi, 0);
      check("rst busy", busy, 0);
      check("rst pull", tx_pull, 0);
      check("rst push", rx_push, 0);
      check("rst rx_data", rx_data, 0);
      check("rst ovf", rx_ovf, 0);
      rst_n = 1'b1;
      enable = 1'b1;
      cyc(2);

      // Table: one frame per entry, MISO looped from MOSI
      for (int i = 0; i < NV; i++) begin
         f0 = frames;
         p0 = pulls;
         q0 = pushes;
         rx_full = tv[i].full;
         put(tv[i].word, 1'b1);
         wait_frames(f0 + 1, $sformatf("vec%0d", i));
         cyc(4);
         check_frame(f0, $sformatf("vec%0d", i));
         check($sformatf("vec%0d pulls", i), pulls - p0, 1);
         check($sformatf("vec%0d pushes", i), pushes - q0, tv[i].exp_push);
         if (tv[i].exp_push != 0)
            check($sformatf("vec%0d rx word", i), rx_log[q0], tv[i].word);
         check($sformatf("vec%0d ovf", i), rx_ovf, tv[i].exp_ovf);
      end
      rx_full = 1'b0;

      // Back-to-back frames and CS high time between them
      f0 = frames;
      p0 = pulls;
      q0 = pushes;
      put(32'h00000001, 1'b1);
      put(32'hFFFFFFFF, 1'b1);
      wait_frames(f0 + 2, "b2b");
      cyc(4);
      check_frame(f0, "b2b first");
      check_frame(f0 + 1, "b2b second");
      check("b2b cs gap", gap_log[f0 + 1], SPI_CS_GAP + 1);
      check("b2b pulls", pulls - p0, 2);
`ifdef SPI_RX_EN
      check("b2b pushes", pushes - q0, 2);
      check("b2b rx0", rx_log[q0], 32'h00000001);
      check("b2b rx1", rx_log[q0 + 1], 32'hFFFFFFFF);
`else
      check("b2b pushes", pushes - q0, 0);
      check("b2b rx_data", rx_data, 0);
`endif

      // Empty FIFO with enable high stays idle
      p0 = pulls;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (busy || !cs_n || sclk) bad++;
      end
      check("empty idle cycles", bad, 0);
      check("empty pulls", pulls - p0, 0);

      // Reset at bit 10 aborts; next word goes out whole
      f0 = frames;
      put(32'h0F0F1234, 1'b0);
      put(32'hDEADBEEF, 1'b1);
      wait_rises(10, "abort");
      rst_n = 1'b0;
      #1;
      check("abort cs_n", cs_n, 1);
      check("abort sclk", sclk, 0);
      check("abort busy", busy, 0);
      check("abort ovf", rx_ovf, 0);
      cyc(3);
      rst_n = 1'b1;
      q0 = pushes;
      wait_frames(f0 + 1, "after abort");
      cyc(4);
      check_frame(f0, "after abort");
`ifdef SPI_RX_EN
      check("after abort rx", rx_log[q0], 32'hDEADBEEF);
`else
      check("after abort pushes", pushes - q0, 0);
`endif

      // Enable drop mid-frame: finish the frame, then hold off
      f0 = frames;
      p0 = pulls;
      put(32'h13579BDF, 1'b1);
      put(32'h2468ACE0, 1'b1);
      wait_rises(5, "en drop");
      enable = 1'b0;
      wait_frames(f0 + 1, "en drop");
      cyc(50);
      check("en drop frames", frames - f0, 1);
      check("en drop pulls", pulls - p0, 1);
      check("en drop busy", busy, 0);
      check("en drop cs_n", cs_n, 1);
      enable = 1'b1;
      wait_frames(f0 + 2, "en resume");
      cyc(4);
      check_frame(f0, "en drop first");
      check_frame(f0 + 1, "en resume");
      check("en resume pulls", pulls - p0, 2);

      check("pull while empty", bad_pulls, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
